// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants for the ALU operand sequencer: datapath width, register
// index width, ALU select encodings and FSM state encodings.
package alu_op_sequencer_pkg;

  localparam int WIDTH    = 5;
  localparam int IDX_W    = 2;
  localparam int NUM_REGS = 4;

  localparam logic [1:0] SEL_AND = 2'b00;
  localparam logic [1:0] SEL_ADD = 2'b01;
  localparam logic [1:0] SEL_OR  = 2'b10;
  localparam logic [1:0] SEL_XOR = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/alu_op_sequencer_regfile.sv
// Operand register file: NUM_REGS x WIDTH, two combinational read ports,
// one synchronous write port, asynchronous clear on rst.
module alu_regfile
  import alu_op_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_addr_a,
  input  logic [IDX_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b
);

  logic [WIDTH-1:0] regs [NUM_REGS];

  // Register storage with single write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-driven operand sequencer feeding an external 5-bit combinational ALU.
// Loads write an immediate directly; operates take one EXEC cycle with the ALU
// operands driven, then write the ALU result back.
// Optional feature: define ALU_SEQ_ZERO_FLAG_EN to add the registered res_zero
// output (written value == 0).
//
// state   | meaning
// IDLE    | cmd_ready=1, loads complete here, operates latch and move to EXEC
// EXEC    | ALU operands driven from latched ra/rb, writeback at end of cycle
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [1:0]       cmd_sel,
  input  logic [IDX_W-1:0] cmd_rd,
  input  logic [IDX_W-1:0] cmd_ra,
  input  logic [IDX_W-1:0] cmd_rb,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  output logic             res_valid,
  output logic [IDX_W-1:0] res_rd,
`ifdef ALU_SEQ_ZERO_FLAG_EN
  output logic             res_zero,
`endif
  output logic [WIDTH-1:0] res_data
);

  state_e           state_q, state_d;
  logic             accept_load, accept_op, in_exec;
  logic [1:0]       sel_q;
  logic [IDX_W-1:0] rd_q, ra_q, rb_q;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_data_a, rd_data_b;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state, handshake and command-accept decode.
  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    accept_load = 1'b0;
    accept_op   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_load) begin
            accept_load = 1'b1;
          end else begin
            accept_op = 1'b1;
            state_d   = ST_EXEC;
          end
        end
      end
      ST_EXEC: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Command register for operates; held through EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= SEL_AND;
      rd_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
    end else if (accept_op) begin
      sel_q <= cmd_sel;
      rd_q  <= cmd_rd;
      ra_q  <= cmd_ra;
      rb_q  <= cmd_rb;
    end
  end

  assign in_exec = (state_q == ST_EXEC);

  // Loads only happen in IDLE and writebacks only at the end of EXEC, so the
  // single write port is never contended.
  assign wr_en   = accept_load | in_exec;
  assign wr_addr = in_exec ? rd_q    : cmd_rd;
  assign wr_data = in_exec ? alu_out : cmd_imm;

  alu_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (ra_q),
    .rd_addr_b (rb_q),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b)
  );

  assign alu_a   = in_exec ? rd_data_a : '0;
  assign alu_b   = in_exec ? rd_data_b : '0;
  assign alu_sel = in_exec ? sel_q     : SEL_AND;

  // Result register: one-cycle strobe plus the index and value just written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_rd    <= '0;
      res_data  <= '0;
    end else begin
      res_valid <= wr_en;
      if (wr_en) begin
        res_rd   <= wr_addr;
        res_data <= wr_data;
      end
    end
  end

`ifdef ALU_SEQ_ZERO_FLAG_EN
  // Zero flag tracks res_data; reset value matches res_data == 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        res_zero <= 1'b1;
    else if (wr_en) res_zero <= (wr_data == '0);
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: spec vector table, hand-written
// backpressure and reset-abort sequences, then randomized commands against
// an array-based reference model. Supports ALU_SEQ_ZERO_FLAG_EN builds.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_load = 1'b0;
  logic [1:0] cmd_sel = 2'b00;
  logic [1:0] cmd_rd = 2'd0, cmd_ra = 2'd0, cmd_rb = 2'd0;
  logic [4:0] cmd_imm = 5'd0;
  logic [4:0] alu_a, alu_b, alu_out;
  logic [1:0] alu_sel;
  logic       res_valid;
  logic [1:0] res_rd;
  logic [4:0] res_data;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic       res_zero;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int mdl [4];

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_load  (cmd_load),
    .cmd_sel   (cmd_sel),
    .cmd_rd    (cmd_rd),
    .cmd_ra    (cmd_ra),
    .cmd_rb    (cmd_rb),
    .cmd_imm   (cmd_imm),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_rd    (res_rd),
`ifdef ALU_SEQ_ZERO_FLAG_EN
    .res_zero  (res_zero),
`endif
    .res_data  (res_data)
  );

  // Downstream combinational ALU.
  always_comb begin
    alu_out = 5'd0;
    case (alu_sel)
      2'b00: alu_out = alu_a & alu_b;
      2'b01: alu_out = alu_a + alu_b;
      2'b10: alu_out = alu_a | alu_b;
      2'b11: alu_out = alu_a ^ alu_b;
      default: alu_out = 5'd0;
    endcase
  end

  function automatic int ref_op(input int sel, input int a, input int b);
    case (sel)
      0: return a & b;
      1: return (a + b) % 32;
      2: return a | b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_result(input string name, input int rd, input int data);
    chk({name, " res_valid"}, int'(res_valid), 1);
    chk({name, " res_rd"}, int'(res_rd), rd);
    chk({name, " res_data"}, int'(res_data), data);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk({name, " res_zero"}, int'(res_zero), (data == 0) ? 1 : 0);
`endif
  endtask

  task automatic junk_fields();
    cmd_load = 1'($urandom);
    cmd_sel  = 2'($urandom);
    cmd_rd   = 2'($urandom);
    cmd_ra   = 2'($urandom);
    cmd_rb   = 2'($urandom);
    cmd_imm  = 5'($urandom);
  endtask

  task automatic drive(input bit ld, input int sel, input int rd, input int ra,
                       input int rb, input int imm);
    cmd_valid = 1'b1;
    cmd_load  = ld;
    cmd_sel   = 2'(sel);
    cmd_rd    = 2'(rd);
    cmd_ra    = 2'(ra);
    cmd_rb    = 2'(rb);
    cmd_imm   = 5'(imm);
  endtask

  // Issue one command starting at edge+1 in an IDLE cycle; returns at edge+1
  // of the cycle carrying its res_valid.
  task automatic do_cmd(input string name, input bit ld, input int sel, input int rd,
                        input int ra, input int rb, input int imm, input int exp);
    drive(ld, sel, rd, ra, rb, imm);
    chk({name, " cmd_ready"}, int'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    junk_fields();
    if (!ld) begin
      chk({name, " exec cmd_ready"}, int'(cmd_ready), 0);
      chk({name, " alu_a"}, int'(alu_a), mdl[ra]);
      chk({name, " alu_b"}, int'(alu_b), mdl[rb]);
      chk({name, " alu_sel"}, int'(alu_sel), sel);
      chk({name, " exec res_valid"}, int'(res_valid), 0);
      @(posedge clk); #1;
    end
    chk_result(name, rd, exp);
    mdl[rd] = exp;
  endtask

  typedef struct {
    bit      load;
    bit [1:0] sel;
    bit [1:0] rd;
    bit [1:0] ra;
    bit [1:0] rb;
    bit [4:0] imm;
    bit [4:0] exp;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int r1, r2;
    tbl[0]  = '{1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 5'd7,  5'd7};
    tbl[1]  = '{1'b1, 2'd0, 2'd1, 2'd0, 2'd0, 5'd12, 5'd12};
    tbl[2]  = '{1'b0, 2'd1, 2'd2, 2'd0, 2'd1, 5'd0,  5'd19};
    tbl[3]  = '{1'b0, 2'd0, 2'd2, 2'd0, 2'd1, 5'd0,  5'd4};
    tbl[4]  = '{1'b0, 2'd2, 2'd2, 2'd0, 2'd1, 5'd0,  5'd15};
    tbl[5]  = '{1'b0, 2'd3, 2'd2, 2'd0, 2'd1, 5'd0,  5'd11};
    tbl[6]  = '{1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 5'd20, 5'd20};
    tbl[7]  = '{1'b1, 2'd0, 2'd1, 2'd0, 2'd0, 5'd15, 5'd15};
    tbl[8]  = '{1'b0, 2'd1, 2'd3, 2'd0, 2'd1, 5'd0,  5'd3};
    tbl[9]  = '{1'b0, 2'd3, 2'd0, 2'd0, 2'd0, 5'd0,  5'd0};
    tbl[10] = '{1'b1, 2'd0, 2'd2, 2'd0, 2'd0, 5'd5,  5'd5};
    tbl[11] = '{1'b0, 2'd1, 2'd2, 2'd2, 2'd2, 5'd0,  5'd10};
    tbl[12] = '{1'b0, 2'd2, 2'd1, 2'd2, 2'd2, 5'd0,  5'd10};
    for (int i = 0; i < 4; i++) mdl[i] = 0;

    // Reset values.
    #23;
    chk("rst cmd_ready", int'(cmd_ready), 1);
    chk("rst alu_a", int'(alu_a), 0);
    chk("rst alu_b", int'(alu_b), 0);
    chk("rst alu_sel", int'(alu_sel), 0);
    chk("rst res_valid", int'(res_valid), 0);
    chk("rst res_rd", int'(res_rd), 0);
    chk("rst res_data", int'(res_data), 0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("rst res_zero", int'(res_zero), 1);
`endif
    #4 rst = 1'b0;
    @(posedge clk); #1;

    // Spec vectors, issued back to back.
    for (int i = 0; i < 13; i++)
      do_cmd($sformatf("tbl%0d", i), tbl[i].load, int'(tbl[i].sel), int'(tbl[i].rd),
             int'(tbl[i].ra), int'(tbl[i].rb), int'(tbl[i].imm), int'(tbl[i].exp));
    @(posedge clk); #1;
    chk("tbl idle res_valid", int'(res_valid), 0);

    // Backpressure: second command held valid during EXEC of the first.
    r1 = ref_op(1, mdl[2], mdl[1]);
    drive(1'b0, 1, 3, 2, 1, 0);
    @(posedge clk); #1;
    drive(1'b0, 2, 0, 3, 2, 0);
    chk("bp exec cmd_ready", int'(cmd_ready), 0);
    chk("bp exec alu_a", int'(alu_a), mdl[2]);
    chk("bp exec res_valid", int'(res_valid), 0);
    @(posedge clk); #1;
    chk_result("bp first", 3, r1);
    chk("bp idle cmd_ready", int'(cmd_ready), 1);
    mdl[3] = r1;
    r2 = ref_op(2, mdl[3], mdl[2]);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("bp second exec cmd_ready", int'(cmd_ready), 0);
    chk("bp second alu_a", int'(alu_a), mdl[3]);
    chk("bp second alu_sel", int'(alu_sel), 2);
    chk("bp second exec res_valid", int'(res_valid), 0);
    @(posedge clk); #1;
    chk_result("bp second", 0, r2);
    mdl[0] = r2;
    @(posedge clk); #1;
    chk("bp single pulse", int'(res_valid), 0);

    // Reset during EXEC aborts the command.
    drive(1'b0, 1, 2, 0, 1, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("abort exec cmd_ready", int'(cmd_ready), 0);
    #2 rst = 1'b1;
    #1;
    chk("abort rst res_valid", int'(res_valid), 0);
    chk("abort rst cmd_ready", int'(cmd_ready), 1);
    chk("abort rst alu_a", int'(alu_a), 0);
    @(posedge clk); #1;
    chk("abort rst2 res_valid", int'(res_valid), 0);
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = 0;
    @(posedge clk); #1;
    chk("abort post res_valid", int'(res_valid), 0);
    chk("abort post cmd_ready", int'(cmd_ready), 1);
    chk("abort post res_data", int'(res_data), 0);
    do_cmd("abort read r2", 1'b0, 2, 1, 2, 2, 0, 0);

    // Randomized commands against the reference model.
    for (int n = 0; n < 300; n++) begin
      bit ld;
      int sel, rd, ra, rb, imm, exp, gap;
      ld  = 1'($urandom);
      sel = int'($urandom_range(3));
      rd  = int'($urandom_range(3));
      ra  = int'($urandom_range(3));
      rb  = int'($urandom_range(3));
      imm = int'($urandom_range(31));
      exp = ld ? imm : ref_op(sel, mdl[ra], mdl[rb]);
      do_cmd($sformatf("rnd%0d", n), ld, sel, rd, ra, rb, imm, exp);
      gap = int'($urandom_range(2));
      for (int g = 0; g < gap; g++) begin
        junk_fields();
        @(posedge clk); #1;
        chk("rnd gap res_valid", int'(res_valid), 0);
        chk("rnd gap cmd_ready", int'(cmd_ready), 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
